// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg : bus-state encoding and default widths shared by the SRAM
//            controller and its device-side responder model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_RD   = 2'd1,
    BUS_WR   = 2'd2
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/sram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sram_rd_pipe : LAT-deep valid/data shift register carrying read snapshots
//                from the request edge to the bus; flush clears every stage.
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sram_rd_pipe #(
  parameter int LAT    = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  logic [LAT-1:0]    valid_q;
  logic [LAT-1:0]    valid_d;
  logic [DATA_W-1:0] data_q [LAT];
  logic [DATA_W-1:0] data_d [LAT];

  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
    // Data stages keep shifting; only the valid bits need clearing.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];
  assign busy      = |valid_q;

endmodule

`default_nettype wire

// File: rtl/sram_responder_model.sv
// ---------------------------------------------------------------------------
// sram_responder_model : device-side model of a 16-bit asynchronous SRAM with
//   configurable read latency, access counters and a contention flag.
//   Optional protocol checker on err_o: define SRAM_MODEL_CHECK_EN.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sram_responder_model
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int DEPTH_W  = 10,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_we_n,
  input  logic              sram_oe_n,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              contention,
  output logic              err_o
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W-1:0] idx;
  logic               wr_req;
  logic               rd_req;
  logic [15:0]        rd_count_d, rd_count_q;
  logic [15:0]        wr_count_d, wr_count_q;
  logic               contention_d, contention_q;
  bus_state_e         state_d, state_q;
  logic               pipe_busy;
  logic               stage_n_valid;
  logic               drive_en;
  logic [DATA_W-1:0]  drive_data;
  logic               unused_addr_hi;

  // Upper address bits alias onto the implemented words.
  assign idx            = sram_addr[DEPTH_W-1:0];
  assign unused_addr_hi = ^sram_addr[ADDR_W-1:DEPTH_W];
  assign wr_req         = ~sram_we_n;
  assign rd_req         = sram_we_n & ~sram_oe_n;

  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem_q[idx] <= sram_data;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_rd
      assign pipe_busy     = 1'b0;
      assign stage_n_valid = 1'b0;
      assign drive_en      = rd_req;
      assign drive_data    = mem_q[idx];
    end else begin : g_piped_rd
      logic [DATA_W-1:0] pipe_data;

      sram_rd_pipe #(
        .LAT    (READ_LAT),
        .DATA_W (DATA_W)
      ) u_rd_pipe (
        .clk       (clk),
        .flush     (rst),
        .in_valid  (rd_req),
        .in_data   (mem_q[idx]),
        .out_valid (stage_n_valid),
        .out_data  (pipe_data),
        .busy      (pipe_busy)
      );

      // A pending write owns the bus; the final-stage word is simply dropped.
      assign drive_en   = stage_n_valid & sram_we_n;
      assign drive_data = pipe_data;
    end
  endgenerate

  assign sram_data = drive_en ? drive_data : {DATA_W{1'bz}};

  always_comb begin
    state_d      = state_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    contention_d = contention_q;

    if (wr_req) begin
      state_d = BUS_WR;
    end else if (!sram_oe_n || pipe_busy) begin
      state_d = BUS_RD;
    end else begin
      state_d = BUS_IDLE;
    end

    if (rd_req) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_req) begin
      wr_count_d = wr_count_q + 16'd1;
    end

    if ((state_d == BUS_WR) && (state_q != BUS_WR) && stage_n_valid) begin
      contention_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BUS_IDLE;
      rd_count_q   <= 16'd0;
      wr_count_q   <= 16'd0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      contention_q <= contention_d;
    end
  end

  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
  assign contention = contention_q;

`ifdef SRAM_MODEL_CHECK_EN
  logic err_d, err_q;

  // $isunknown only ever fires in a four-state simulator.
  always_comb begin
    err_d = err_q;
    if (wr_req && (!sram_oe_n || $isunknown(sram_data))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_responder_model.sv
// ---------------------------------------------------------------------------
// tb_sram_responder_model : scoreboard bench driving three model instances
//   (READ_LAT = 0, 2, 3) with directed access sequences.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_responder_model;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] addr  [NDUT];
  logic        we_n  [NDUT];
  logic        oe_n  [NDUT];
  logic        drv   [NDUT];
  logic [15:0] wdata [NDUT];
  logic [15:0] rd_cnt [NDUT];
  logic [15:0] wr_cnt [NDUT];
  logic        cont   [NDUT];
  logic        err    [NDUT];
  logic [15:0] bus_v  [NDUT];

  tri1 [15:0] bus0;
  tri1 [15:0] bus1;
  tri1 [15:0] bus2;

  assign bus0 = drv[0] ? wdata[0] : 16'hzzzz;
  assign bus1 = drv[1] ? wdata[1] : 16'hzzzz;
  assign bus2 = drv[2] ? wdata[2] : 16'hzzzz;
  assign bus_v[0] = bus0;
  assign bus_v[1] = bus1;
  assign bus_v[2] = bus2;

  sram_responder_model #(.READ_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .sram_addr(addr[0]), .sram_we_n(we_n[0]),
    .sram_oe_n(oe_n[0]), .sram_data(bus0), .rd_count(rd_cnt[0]),
    .wr_count(wr_cnt[0]), .contention(cont[0]), .err_o(err[0]));

  sram_responder_model #(.READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .sram_addr(addr[1]), .sram_we_n(we_n[1]),
    .sram_oe_n(oe_n[1]), .sram_data(bus1), .rd_count(rd_cnt[1]),
    .wr_count(wr_cnt[1]), .contention(cont[1]), .err_o(err[1]));

  sram_responder_model #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .sram_addr(addr[2]), .sram_we_n(we_n[2]),
    .sram_oe_n(oe_n[2]), .sram_data(bus2), .rd_count(rd_cnt[2]),
    .wr_count(wr_cnt[2]), .contention(cont[2]), .err_o(err[2]));

  typedef struct {
    int          dut;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // A released bus reads as all-ones (pull-up) or all-zeros (two-state sim).
  function automatic bit undriven(logic [15:0] v);
    return (v === 16'hFFFF) || (v === 16'h0000);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle the model drives a bus, the oldest expectation must match.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!drv[d] && !undriven(bus_v[d])) begin
        exp_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_drive dut%0d: got %h at cycle %0d, required Z", d, bus_v[d], cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.dut != d || e.data !== bus_v[d] || e.due != cyc) begin
            n_fail++;
            $display("FAIL read_data dut%0d: got %h at cycle %0d, required dut%0d %h at cycle %0d",
                     d, bus_v[d], cyc, e.dut, e.data, e.due);
          end
        end
      end
    end
    if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_read dut%0d: got no drive, required %h at cycle %0d",
               exp_q[0].dut, exp_q[0].data, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  task automatic set_idle(int d);
    we_n[d] = 1'b1;
    oe_n[d] = 1'b1;
    drv[d]  = 1'b0;
  endtask

  task automatic cyc_write(int d, logic [17:0] a, logic [15:0] v, bit oe_low = 1'b0);
    @(posedge clk); #1;
    addr[d]  = a;
    we_n[d]  = 1'b0;
    oe_n[d]  = !oe_low;
    drv[d]   = 1'b1;
    wdata[d] = v;
  endtask

  task automatic cyc_read(int d, logic [17:0] a, logic [15:0] v, int lat, bit expect_data = 1'b1);
    @(posedge clk); #1;
    addr[d] = a;
    we_n[d] = 1'b1;
    oe_n[d] = 1'b0;
    drv[d]  = 1'b0;
    if (expect_data) exp_q.push_back('{d, v, cyc + lat});
  endtask

  task automatic cyc_idle(int d, int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_idle(d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      set_idle(d);
      addr[d]  = '0;
      wdata[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_rd_count%0d", d), rd_cnt[d], 0);
      check($sformatf("rst_wr_count%0d", d), wr_cnt[d], 0);
      check($sformatf("rst_contention%0d", d), cont[d], 0);
      check($sformatf("rst_err%0d", d), err[d], 0);
      check($sformatf("rst_bus_z%0d", d), undriven(bus_v[d]), 1);
    end

    // Combinational read path, aliasing and dual-enable checker.
    cyc_write(0, 18'h00010, 16'hBEEF);
    cyc_read (0, 18'h00010, 16'hBEEF, 0);
    cyc_idle (0, 2);
    @(negedge clk);
    check("lat0_wr_count", wr_cnt[0], 1);
    check("lat0_rd_count", rd_cnt[0], 1);
    cyc_write(0, 18'h003FF, 16'h0F0F, 1'b1);
    cyc_read (0, 18'h007FF, 16'h0F0F, 0);
    cyc_write(0, 18'h00400, 16'h1357);
    cyc_read (0, 18'h00000, 16'h1357, 0);
    cyc_idle (0, 3);
    @(negedge clk);
`ifdef SRAM_MODEL_CHECK_EN
    check("lat0_err_both_low", err[0], 1);
`else
    check("lat0_err_tied", err[0], 0);
`endif
    check("lat0_wr_count3", wr_cnt[0], 3);
    check("lat0_rd_count3", rd_cnt[0], 3);
    cyc_idle(0, 2);
    @(negedge clk);
    check("lat0_rd_hold", rd_cnt[0], 3);
    check("lat0_wr_hold", wr_cnt[0], 3);

    // Two-cycle latency, back-to-back, snapshot and contention.
    cyc_write(1, 18'h00011, 16'h1234);
    cyc_write(1, 18'h00010, 16'hBEEF);
    cyc_write(1, 18'h00020, 16'hAAAA);
    cyc_read (1, 18'h00011, 16'h1234, 2);
    @(negedge clk);
    check("lat2_z_req_cycle", undriven(bus_v[1]), 1);
    cyc_idle(1, 1);
    @(negedge clk);
    check("lat2_z_next_cycle", undriven(bus_v[1]), 1);
    cyc_idle(1, 3);
    cyc_read (1, 18'h00010, 16'hBEEF, 2);
    cyc_read (1, 18'h00011, 16'h1234, 2);
    cyc_idle (1, 4);
    cyc_read (1, 18'h00020, 16'hAAAA, 2);
    cyc_write(1, 18'h00020, 16'h5555);
    cyc_idle (1, 3);
    @(negedge clk);
    check("lat2_snapshot_no_contention", cont[1], 0);
    cyc_read (1, 18'h00020, 16'h5555, 2);
    cyc_idle (1, 3);
    cyc_read (1, 18'h00010, 16'h0000, 2, 1'b0);
    cyc_idle (1, 1);
    cyc_write(1, 18'h00030, 16'h7777);
    @(negedge clk);
    check("lat2_bus_owned_by_writer", bus_v[1], 16'h7777);
    check("lat2_contention_before_edge", cont[1], 0);
    cyc_idle(1, 1);
    @(negedge clk);
    check("lat2_contention_set", cont[1], 1);
    cyc_idle(1, 4);
    @(negedge clk);
    check("lat2_contention_sticky", cont[1], 1);
    cyc_read(1, 18'h00030, 16'h7777, 2);
    cyc_idle(1, 3);
    @(negedge clk);
    check("lat2_rd_count", rd_cnt[1], 7);
    check("lat2_wr_count", wr_cnt[1], 5);

    // Reset with two reads in flight on the three-stage pipeline.
    cyc_write(2, 18'h00010, 16'hBEEF);
    cyc_write(2, 18'h00011, 16'h4321);
    cyc_read (2, 18'h00010, 16'h0000, 3, 1'b0);
    cyc_read (2, 18'h00011, 16'h0000, 3, 1'b0);
    @(posedge clk); #1;
    set_idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("lat3_rst_rd_count", rd_cnt[2], 0);
    check("lat3_rst_wr_count", wr_cnt[2], 0);
    check("lat3_rst_bus_z", undriven(bus_v[2]), 1);
    check("lat2_contention_cleared", cont[1], 0);
    check("lat2_wr_count_cleared", wr_cnt[1], 0);
    cyc_idle(2, 4);
    cyc_read(2, 18'h00010, 16'hBEEF, 3);
    cyc_idle(2, 5);
    @(negedge clk);
    check("lat3_rd_after_rst", rd_cnt[2], 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_responder_model.md
Name: sram_responder_model

Overview:
- Synthesizable/simulatable model of the external 16-bit asynchronous SRAM, i.e. the device end of the SRAM controller bus.
- Sits on the board-level side of the controller's address, WE_N, OE_N and bidirectional data pins in system testbenches and FPGA-internal builds.
- Stores 16-bit words, returns reads after a configurable latency, and commits writes on the clock edge.
- Tracks bus direction with a small FSM and exposes access counters plus a contention flag.

Parameters:
- ADDR_W, 18, width of sram_addr.
- DATA_W, 16, width of the sram_data word.
- DEPTH_W, 10, implemented words = 2^DEPTH_W; only sram_addr[DEPTH_W-1:0] is decoded and upper bits alias.
- READ_LAT, 0, cycles from OE_N low to data driven; 0 = combinational, 1..4 = registered.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sram_addr  in  ADDR_W  word address.
- sram_we_n  in  1  write enable, active low.
- sram_oe_n  in  1  output enable, active low.
- sram_data  inout  DATA_W  data bus; Z whenever the model is not driving.
- rd_count  out  16  number of read cycles accepted; wraps at 16'hFFFF -> 0.
- wr_count  out  16  number of write cycles committed; wraps.
- contention  out  1  sticky flag: a write arrived while read data was still being driven.
- err_o  out  1  protocol error flag (see Optional Feature).

Behaviour:
- Reset:
  - Clears rd_count, wr_count, contention, err_o, all read-pipeline valid bits, and sets FSM to IDLE.
  - Memory contents are not cleared.
  - sram_data is Z in the cycle after reset is sampled.
  - Reset asserted mid-read drops in-flight data; no drive occurs after the reset edge.
- Write: on posedge clk with sram_we_n=0, mem[addr] <= sram_data and wr_count increments. Write has priority over OE_N.
- Read request: the cycle qualifies as a read when sram_we_n=1 and sram_oe_n=0; rd_count increments on that edge.
- READ_LAT=0:
  - sram_data = mem[addr] combinationally while the read condition holds.
  - A write to the same address becomes visible after the write edge.
- READ_LAT=N>0:
  - At the request edge, stage1 <= {valid, mem[addr]} as a snapshot.
  - The snapshot shifts one stage per clock and is driven while stageN is valid and sram_we_n=1.
  - A write to the same address while the read is in flight does not alter the returned snapshot.
  - Back-to-back reads pipeline at one per cycle.
- Bus FSM, states IDLE, RD, WR; transitions evaluated each posedge:
  - we_n=0 -> WR.
  - else oe_n=0 or pipeline non-empty -> RD.
  - else -> IDLE.
- Contention:
  - Entering WR while stageN is valid sets contention (sticky until rst).
  - The drive is suppressed that cycle and the stageN data is discarded.
- Both OE_N and WE_N high with an empty pipeline: no drive, counters hold.
- Counter increments are mod 2^16.
- Address bits above DEPTH_W are ignored; addr 0x00400 and 0x00000 alias when DEPTH_W=10.

Optional Feature:
- Macro: SRAM_MODEL_CHECK_EN.
- Defined:
  - err_o is set (sticky) when sram_we_n=0 and sram_oe_n=0 in the same cycle; the write still commits.
  - err_o is also set when a write's sram_data has any X/Z bit (simulation only).
- Undefined: err_o is tied 0 and no checker logic is built.

Decomposition:
- Shared package sram_pkg holds:
  - bus-state encoding (IDLE=0, RD=1, WR=2);
  - default ADDR_W/DATA_W constants, shared with the controller.
- One sub-module, sram_rd_pipe: a READ_LAT-deep valid/data shift register with a flush input, used for the registered read path.

Test Plan:
- Write then read (READ_LAT=0): write 0xBEEF @0x00010, then OE_N low @0x00010 -> sram_data=0xBEEF the same cycle; wr_count=1, rd_count=1.
- Read latency (READ_LAT=2): read @0x00011 holding 0x1234 -> bus Z for 2 cycles, 0x1234 on cycle 3; back-to-back reads @0x10 and @0x11 -> consecutive data cycles.
- Snapshot (READ_LAT=2): read @0x20 (0xAAAA), write 0x5555 @0x20 on the next cycle -> read returns 0xAAAA and contention stays 0 because the pipeline was not yet at stageN; a later read returns 0x5555.
- Contention: with stageN valid, drive WE_N low -> contention=1, bus not driven by the model, and the value stays 1 until rst.
- Reset mid-read (READ_LAT=3): assert rst with 2 reads in flight -> no drive after reset, counters=0, memory retains 0xBEEF @0x10.
- Checker (SRAM_MODEL_CHECK_EN): WE_N=OE_N=0 with 0x0F0F @0x3FF -> err_o=1 and mem[0x3FF]=0x0F0F; aliasing check: a read @0x007FF returns 0x0F0F.
